// File: rtl/led_display_sink_decoder.sv
// Receiver for the two-shifter serial LED display link: rebuilds the displayed 16-bit hex number.
// Optional frame counter output o_frame_count is enabled by defining LED_SINK_STATS_EN.
module led_display_sink_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 25000,
  parameter int unsigned TIMEOUT_WIDTH  = 15
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_shifter_a_ds,
  input  logic        i_shifter_b_ds,
  input  logic        i_shifter_a_cp,
  input  logic        i_shifter_b_cp,
  input  logic        i_shifter_a_mr_n,
  input  logic        i_shifter_b_mr_n,
  output logic [15:0] o_number,
  output logic [3:0]  o_digit_valid,
  output logic        o_frame_stb,
  output logic        o_decode_err,
  output logic        o_timeout_err
`ifdef LED_SINK_STATS_EN
  ,
  output logic [15:0] o_frame_count
`endif
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0]         FULL_CNT = CNT_W'(8);
  localparam logic [TIMEOUT_WIDTH-1:0] TMO_CNT  = TIMEOUT_WIDTH'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_COMMIT} state_t;

  state_t state_q, state_d;

  logic [5:0] sync1_q, sync2_q;
  logic [1:0] cp_prev_q;
  logic       ds_a_s, ds_b_s, cp_a_s, cp_b_s, mr_a_n_s, mr_b_n_s;
  logic       rise_a, rise_b, mr_any;

  // Segment shifter keeps only 7 bits: the dp bit is shifted in first and falls off the top.
  logic [6:0]               sh_a_q;
  logic [7:0]               sh_b_q;
  logic [CNT_W-1:0]         cnt_a_q, cnt_b_q;
  logic [TIMEOUT_WIDTH-1:0] tcnt_q;

  logic       frame_done, overrun, timeout_hit;
  logic       sel_ok, frame_ok;
  logic [1:0] sel_idx;
  logic [4:0] seg_dec;

  logic frame_stb_d, decode_err_d, timeout_err_d, upd_en, clr_frame, clr_cnt;

  // Two-flop synchronisers for all six asynchronous link inputs.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      cp_prev_q <= '0;
    end else begin
      sync1_q   <= {i_shifter_b_mr_n, i_shifter_a_mr_n, i_shifter_b_cp,
                    i_shifter_a_cp, i_shifter_b_ds, i_shifter_a_ds};
      sync2_q   <= sync1_q;
      cp_prev_q <= sync2_q[3:2];
    end
  end

  assign ds_a_s   = sync2_q[0];
  assign ds_b_s   = sync2_q[1];
  assign cp_a_s   = sync2_q[2];
  assign cp_b_s   = sync2_q[3];
  assign mr_a_n_s = sync2_q[4];
  assign mr_b_n_s = sync2_q[5];
  assign rise_a   = cp_a_s & ~cp_prev_q[0];
  assign rise_b   = cp_b_s & ~cp_prev_q[1];
  assign mr_any   = ~mr_a_n_s | ~mr_b_n_s;

  assign frame_done  = (cnt_a_q == FULL_CNT) && (cnt_b_q == FULL_CNT);
  assign overrun     = (rise_a && (cnt_a_q >= FULL_CNT)) || (rise_b && (cnt_b_q >= FULL_CNT));
  assign timeout_hit = (tcnt_q == TMO_CNT);

  function automatic logic [4:0] seg_to_nibble(input logic [6:0] seg);
    case (seg)
      7'h3F:   return 5'h10;
      7'h06:   return 5'h11;
      7'h5B:   return 5'h12;
      7'h4F:   return 5'h13;
      7'h66:   return 5'h14;
      7'h6D:   return 5'h15;
      7'h7D:   return 5'h16;
      7'h07:   return 5'h17;
      7'h7F:   return 5'h18;
      7'h6F:   return 5'h19;
      7'h77:   return 5'h1A;
      7'h7C:   return 5'h1B;
      7'h39:   return 5'h1C;
      7'h5E:   return 5'h1D;
      7'h79:   return 5'h1E;
      7'h71:   return 5'h1F;
      default: return 5'h00;
    endcase
  endfunction

  // Digit select must be exactly one of the low four bits.
  always_comb begin
    sel_ok  = 1'b1;
    sel_idx = 2'd0;
    case (sh_b_q)
      8'h01:   sel_idx = 2'd0;
      8'h02:   sel_idx = 2'd1;
      8'h04:   sel_idx = 2'd2;
      8'h08:   sel_idx = 2'd3;
      default: sel_ok  = 1'b0;
    endcase
  end

  assign seg_dec  = seg_to_nibble(sh_a_q);
  assign frame_ok = sel_ok & seg_dec[4];

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (mr_any) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   if (rise_a || rise_b) state_d = ST_SHIFT;
        ST_SHIFT: begin
          if (frame_done)                  state_d = ST_COMMIT;
          else if (overrun || timeout_hit) state_d = ST_IDLE;
        end
        ST_COMMIT: state_d = (rise_a || rise_b) ? ST_SHIFT : ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // Strobes are decided on the transition into COMMIT so they register one edge after the last shift.
  always_comb begin
    frame_stb_d   = 1'b0;
    decode_err_d  = 1'b0;
    timeout_err_d = 1'b0;
    upd_en        = 1'b0;
    clr_frame     = 1'b0;
    clr_cnt       = 1'b0;
    if (!mr_any) begin
      case (state_q)
        ST_SHIFT: begin
          if (frame_done) begin
            frame_stb_d  = 1'b1;
            upd_en       = frame_ok;
            decode_err_d = ~frame_ok;
          end else if (overrun) begin
            decode_err_d = 1'b1;
            clr_frame    = 1'b1;
          end else if (timeout_hit) begin
            timeout_err_d = 1'b1;
            clr_frame     = 1'b1;
          end
        end
        ST_COMMIT: clr_cnt = 1'b1;
        default:   ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      sh_a_q  <= '0;
      cnt_a_q <= '0;
    end else if (!mr_a_n_s || clr_frame) begin
      sh_a_q  <= '0;
      cnt_a_q <= '0;
    end else if (rise_a) begin
      sh_a_q  <= {sh_a_q[5:0], ds_a_s};
      cnt_a_q <= clr_cnt ? CNT_W'(1) : cnt_a_q + CNT_W'(1);
    end else if (clr_cnt) begin
      cnt_a_q <= '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      sh_b_q  <= '0;
      cnt_b_q <= '0;
    end else if (!mr_b_n_s || clr_frame) begin
      sh_b_q  <= '0;
      cnt_b_q <= '0;
    end else if (rise_b) begin
      sh_b_q  <= {sh_b_q[6:0], ds_b_s};
      cnt_b_q <= clr_cnt ? CNT_W'(1) : cnt_b_q + CNT_W'(1);
    end else if (clr_cnt) begin
      cnt_b_q <= '0;
    end
  end

  // Inactivity timer: only runs mid-frame, restarts on every shift clock edge.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n)                                   tcnt_q <= '0;
    else if (state_q != ST_SHIFT || rise_a || rise_b) tcnt_q <= '0;
    else                                              tcnt_q <= tcnt_q + TIMEOUT_WIDTH'(1);
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      o_number      <= '0;
      o_digit_valid <= '0;
      o_frame_stb   <= 1'b0;
      o_decode_err  <= 1'b0;
      o_timeout_err <= 1'b0;
    end else begin
      o_frame_stb   <= frame_stb_d;
      o_decode_err  <= decode_err_d;
      o_timeout_err <= timeout_err_d;
      if (upd_en) begin
        o_number[{sel_idx, 2'b00} +: 4] <= seg_dec[3:0];
        o_digit_valid[sel_idx]          <= 1'b1;
      end
    end
  end

`ifdef LED_SINK_STATS_EN
  always_ff @(posedge i_clk) begin
    if (!i_reset_n)  o_frame_count <= '0;
    else if (upd_en) o_frame_count <= o_frame_count + 16'd1;
  end
`endif

endmodule

// File: doc/led_display_sink_decoder.md
Name: led_display_sink_decoder

Overview:
Receiving end of the two-shifter serial LED display interface. Emulates the pair of 8-bit serial-in shift registers: A carries the segment pattern, B carries the digit select. Decodes each completed frame back into a hex nibble and rebuilds the 16-bit number being displayed. Used as a loopback checker on the board and as the bench-side monitor for the display controller.

Parameters:
TIMEOUT_CYCLES, 25000, i_clk cycles without a CP rise mid-frame before the partial frame is abandoned (1 ms at 25 MHz)
TIMEOUT_WIDTH, 15, width of the timeout counter; must hold TIMEOUT_CYCLES

Ports:
i_clk  in  1  system clock
i_reset_n  in  1  reset, synchronous, active-low; clock i_clk
i_shifter_a_ds  in  1  serial data, segment shifter (async to i_clk)
i_shifter_b_ds  in  1  serial data, digit-select shifter (async)
i_shifter_a_cp  in  1  shift clock A, rising-edge active (async)
i_shifter_b_cp  in  1  shift clock B, rising-edge active (async)
i_shifter_a_mr_n  in  1  master reset A, active-low (async)
i_shifter_b_mr_n  in  1  master reset B, active-low (async)
o_number  out  16  reconstructed number; digit k = o_number[4k+3:4k]
o_digit_valid  out  4  bit k set once digit k has been decoded
o_frame_stb  out  1  one-cycle pulse per committed frame
o_decode_err  out  1  one-cycle pulse: bad segment, bad select or overrun
o_timeout_err  out  1  one-cycle pulse: partial frame abandoned on timeout

Behaviour:
- All six inputs pass through 2-flop synchronisers. A CP rise is sync2 high while the previous sync2 was low.
- Shift on a CP rise: sh_x <= {sh_x[6:0], ds_x}, MSB first, using the synchronised DS sampled in the same cycle. cnt_x (4 bits) increments.
- Synchronised MR_n low clears sh_x and cnt_x of that shifter, returns the FSM to IDLE and discards the partial frame without error. If MR_n and a CP rise occur in the same cycle, MR_n wins.
- FSM states: IDLE, SHIFT, COMMIT.
  - IDLE -> SHIFT on the first CP rise of either shifter.
  - SHIFT -> COMMIT when cnt_a == 8 and cnt_b == 8. Both shifters need not reach 8 in the same cycle.
  - SHIFT: a 9th CP rise on either shifter before commit is an overrun. Pulse o_decode_err, clear both shifters and counts, go to IDLE.
  - SHIFT: when the timeout counter reaches TIMEOUT_CYCLES, pulse o_timeout_err, clear both shifters and counts, go to IDLE. The timeout counter reloads to 0 on every CP rise and in IDLE.
  - COMMIT (one cycle): decode, pulse o_frame_stb, clear counts, go to IDLE.
- Decode rules:
  - sh_b must be exactly one-hot in bits [3:0] with [7:4] = 0. The set bit k selects the digit.
  - sh_a[6:0] is segments g..a, active-high. sh_a[7] (dp) is ignored.
  - Segment table, 0..F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
  - Valid frame: o_number[4k+3:4k] <= nibble; o_digit_valid[k] <= 1.
  - Invalid select or unknown pattern: o_decode_err pulses with o_frame_stb. o_number and o_digit_valid are unchanged.
- Latency: let raw CP be first sampled high at clock edge N for the 8th bit of the later shifter. The shift occurs at edge N+2. o_frame_stb, o_decode_err and the o_number update are registered at edge N+3.
- Reset values: o_number 0, o_digit_valid 0, all strobes 0, FSM IDLE, shifters, counters and synchronisers 0. Reset mid-frame discards the frame with no strobes.

Optional Feature:
LED_SINK_STATS_EN:
- Defined: adds output o_frame_count (16-bit). It increments on every o_frame_stb whose decode is valid and wraps FFFF -> 0000. Reset value 0.
- Undefined: the port and the counter are absent. All other behaviour is identical.

Test Plan:
- Send 4 valid frames: (sel 01, seg 4F), (02, 5B), (04, 06), (08, 3F) -> o_number 16'h0123, o_digit_valid 4'hF, 4 o_frame_stb pulses, no errors.
- Frame with seg 00, sel 01 -> o_frame_stb and o_decode_err in the same cycle, o_number unchanged.
- Frame with sel 03, seg 06 -> o_decode_err; o_digit_valid unchanged.
- 5 bits shifted, then MR_n low for 4 cycles, then full frame (sel 02, seg 7F) -> no error from the partial frame; o_number[7:4] = 8.
- 3 CP rises, then idle TIMEOUT_CYCLES+5 cycles (TIMEOUT_CYCLES = 100 in sim) -> exactly one o_timeout_err pulse, FSM IDLE, next frame decodes normally.
- 9 CP rises on A while B gives 7 -> o_decode_err overrun pulse, no o_frame_stb.
- i_reset_n low mid-frame -> all outputs 0 the next cycle, no strobe after release.
